// File: rtl/raster_fetch_sched_pkg.sv
// Shared video definitions: frame geometry, VRAM bus-owner codes and scheduler states.
package raster_fetch_sched_pkg;

    localparam int unsigned VACTIVE_LINES = 240;
    localparam int unsigned VTOTAL_LINES  = 270;

    localparam logic [3:0] OWN_NONE   = 4'd0;
    localparam logic [3:0] OWN_CPU    = 4'd1;
    localparam logic [3:0] OWN_LAYER0 = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU,
        ST_START,
        ST_WAIT
    } sched_state_t;

endpackage

// File: rtl/raster_fetch_sched_timeout.sv
// Per-layer fetch watchdog: clear on launch, count while waiting, flag terminal count.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/raster_fetch_sched.sv
// Scanline fetch scheduler: arbitrates the VRAM port between line-buffer engines and the CPU.
module raster_fetch_sched
    import raster_fetch_sched_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned VACTIVE    = VACTIVE_LINES,
    parameter int unsigned VTOTAL     = VTOTAL_LINES,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hbl,
    input  logic [8:0]            vc,
    output logic [NUM_LAYERS-1:0] fetch_start,
    output logic [8:0]            fetch_line,
    input  logic [NUM_LAYERS-1:0] fetch_done,
    output logic                  fetch_abort,
    input  logic                  cpu_req,
    output logic                  cpu_ack,
    output logic [3:0]            bus_owner,
    output logic [NUM_LAYERS-1:0] overrun,
    input  logic                  ovr_clr
);

    sched_state_t          state, next_state;
    logic [2:0]            idx, idx_next;
    logic                  hbl_q;
    logic                  pending;
    logic                  clear_pending;
    logic [NUM_LAYERS-1:0] ovr_set;
    logic [NUM_LAYERS-1:0] layer_onehot;
    logic [8:0]            target;
    logic                  line_evt, line_accept, hbl_fall;
    logic                  last_layer, done_sel;
    logic                  ctr_clear, ctr_en, ctr_tc;

    assign line_evt     = hbl & ~hbl_q;
    assign hbl_fall     = hbl_q & ~hbl;
    assign target       = (vc == 9'(VTOTAL - 1)) ? '0 : vc + 9'd1;
    // Events arriving while a fetch owns the bus are glitches and are dropped.
    assign line_accept  = line_evt && (state == ST_IDLE || state == ST_CPU) &&
                          (target < 9'(VACTIVE));
    assign layer_onehot = NUM_LAYERS'(1) << idx;
    assign last_layer   = (idx == 3'(NUM_LAYERS - 1));
    assign done_sel     = |(fetch_done & layer_onehot);

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clear),
        .enable (ctr_en),
        .tc     (ctr_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            hbl_q      <= 1'b0;
            pending    <= 1'b0;
            fetch_line <= '0;
            overrun    <= '0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
            hbl_q <= hbl;
            if (line_accept) begin
                pending    <= 1'b1;
                fetch_line <= target;
            end else if (clear_pending) begin
                pending <= 1'b0;
            end
            if (ovr_clr) begin
                overrun <= '0;
            end else begin
                overrun <= overrun | ovr_set;
            end
        end
    end

    always_comb begin
        next_state    = state;
        idx_next      = idx;
        clear_pending = 1'b0;
        fetch_abort   = 1'b0;
        ovr_set       = '0;
        fetch_start   = '0;
        cpu_ack       = 1'b0;
        bus_owner     = OWN_NONE;
        ctr_clear     = 1'b0;
        ctr_en        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pending && !hbl_fall) begin
                    next_state = ST_START;
                    idx_next   = '0;
                end else if (cpu_req) begin
                    next_state = ST_CPU;
                end
            end
            ST_CPU: begin
                cpu_ack   = 1'b1;
                bus_owner = OWN_CPU;
                if (!cpu_req) begin
                    next_state = ST_IDLE;
                end
            end
            ST_START: begin
                bus_owner = OWN_LAYER0 + 4'(idx);
                ctr_clear = 1'b1;
                if (hbl_fall) begin
                    fetch_abort   = 1'b1;
                    ovr_set       = layer_onehot;
                    clear_pending = 1'b1;
                    next_state    = ST_IDLE;
                end else begin
                    fetch_start = layer_onehot;
                    next_state  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus_owner = OWN_LAYER0 + 4'(idx);
                ctr_en    = 1'b1;
                // Completion beats both deadline and watchdog; the deadline still ends the line.
                if (done_sel) begin
                    if (last_layer || hbl_fall) begin
                        clear_pending = 1'b1;
                        next_state    = ST_IDLE;
                    end else begin
                        idx_next   = idx + 3'd1;
                        next_state = ST_START;
                    end
                end else if (hbl_fall || ctr_tc) begin
                    fetch_abort = 1'b1;
                    ovr_set     = layer_onehot;
                    if (hbl_fall || last_layer) begin
                        clear_pending = 1'b1;
                        next_state    = ST_IDLE;
                    end else begin
                        idx_next   = idx + 3'd1;
                        next_state = ST_START;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase

        if ((state == ST_IDLE || state == ST_CPU) && hbl_fall) begin
            clear_pending = 1'b1;
        end
    end

endmodule

// File: tb/tb_raster_fetch_sched.sv
// Directed self-checking bench for the scanline fetch scheduler.
module tb_raster_fetch_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       hbl;
    logic [8:0] vc;
    logic [3:0] fetch_start;
    logic [8:0] fetch_line;
    logic [3:0] fetch_done;
    logic       fetch_abort;
    logic       cpu_req;
    logic       cpu_ack;
    logic [3:0] bus_owner;
    logic [3:0] overrun;
    logic       ovr_clr;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int abort_cnt = 0;
    int snap_s;
    int snap_a;

    raster_fetch_sched #(
        .NUM_LAYERS (4),
        .VACTIVE    (240),
        .VTOTAL     (270),
        .TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hbl         (hbl),
        .vc          (vc),
        .fetch_start (fetch_start),
        .fetch_line  (fetch_line),
        .fetch_done  (fetch_done),
        .fetch_abort (fetch_abort),
        .cpu_req     (cpu_req),
        .cpu_ack     (cpu_ack),
        .bus_owner   (bus_owner),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fetch_start != 4'd0) start_cnt++;
        if (fetch_abort) abort_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; hbl = 1'b0; vc = 9'd0; fetch_done = 4'd0; cpu_req = 1'b0; ovr_clr = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_start", 16'(fetch_start), 16'h0);
        chk("rst_line", 16'(fetch_line), 16'h0);
        chk("rst_owner", 16'(bus_owner), 16'h0);
        chk("rst_ovr", 16'(overrun), 16'h0);
        chk("rst_ack", 16'(cpu_ack), 16'h0);
        chk("rst_abort", 16'(fetch_abort), 16'h0);

        // Normal line: done 5 cycles after each start
        snap_s = start_cnt;
        vc = 9'd10; hbl = 1'b1;
        tick(); #1;
        chk("norm_latency", 16'(fetch_start), 16'h0);
        tick(); #1;
        chk("norm_line", 16'(fetch_line), 16'd11);
        for (int i = 0; i < 4; i++) begin
            chk("norm_start", 16'(fetch_start), 16'(4'b0001 << i));
            chk("norm_owner", 16'(bus_owner), 16'(2 + i));
            repeat (4) tick();
            tick(); fetch_done = 4'(4'b0001 << i);
            tick(); fetch_done = 4'd0;
            #1;
        end
        chk("norm_idle_owner", 16'(bus_owner), 16'h0);
        chk("norm_ovr", 16'(overrun), 16'h0);
        chk("norm_count", 16'(start_cnt - snap_s), 16'd4);
        hbl = 1'b0; tick();

        // Frame wrap
        vc = 9'd269; hbl = 1'b1;
        tick(); tick(); #1;
        chk("wrap_line", 16'(fetch_line), 16'h0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_start", 16'(fetch_start), 16'(4'b0001 << i));
            tick(); fetch_done = 4'(4'b0001 << i);
            tick(); fetch_done = 4'd0;
            #1;
        end
        chk("wrap_idle", 16'(bus_owner), 16'h0);
        hbl = 1'b0; tick();

        // Vblank lines: no fetches
        snap_s = start_cnt;
        vc = 9'd239; hbl = 1'b1;
        repeat (5) tick();
        hbl = 1'b0; tick();
        vc = 9'd250; hbl = 1'b1;
        repeat (5) tick();
        hbl = 1'b0; tick(); tick(); #1;
        chk("vblank_nostart", 16'(start_cnt - snap_s), 16'h0);
        chk("vblank_line_hold", 16'(fetch_line), 16'h0);

        // Timeout on layer 1
        vc = 9'd20; hbl = 1'b1;
        tick(); tick();
        tick(); fetch_done = 4'b0001;
        tick(); fetch_done = 4'd0;
        #1;
        chk("to_start1", 16'(fetch_start), 16'b0010);
        repeat (63) tick();
        #1;
        chk("to_noabort_early", 16'(fetch_abort), 16'h0);
        tick(); #1;
        chk("to_abort", 16'(fetch_abort), 16'h1);
        tick(); #1;
        chk("to_start2", 16'(fetch_start), 16'b0100);
        chk("to_ovr", 16'(overrun), 16'b0010);
        chk("to_abort_clear", 16'(fetch_abort), 16'h0);
        tick(); fetch_done = 4'b0100;
        tick(); fetch_done = 4'd0;
        #1;
        chk("to_start3", 16'(fetch_start), 16'b1000);
        tick(); fetch_done = 4'b1000;
        tick(); fetch_done = 4'd0;
        #1;
        chk("to_idle", 16'(bus_owner), 16'h0);
        chk("to_ovr_sticky", 16'(overrun), 16'b0010);
        ovr_clr = 1'b1;
        tick(); ovr_clr = 1'b0;
        #1;
        chk("to_ovr_clr", 16'(overrun), 16'h0);
        hbl = 1'b0; tick();

        // Deadline while layer 2 waits
        snap_s = start_cnt;
        vc = 9'd30; hbl = 1'b1;
        tick(); tick();
        tick(); fetch_done = 4'b0001;
        tick(); fetch_done = 4'd0;
        tick(); fetch_done = 4'b0010;
        tick(); fetch_done = 4'd0;
        #1;
        chk("dl_start2", 16'(fetch_start), 16'b0100);
        tick(); tick();
        hbl = 1'b0; cpu_req = 1'b1;
        #1;
        chk("dl_abort", 16'(fetch_abort), 16'h1);
        chk("dl_owner", 16'(bus_owner), 16'd4);
        tick(); #1;
        chk("dl_ovr", 16'(overrun), 16'b0100);
        chk("dl_ack_wait", 16'(cpu_ack), 16'h0);
        tick(); #1;
        chk("dl_ack", 16'(cpu_ack), 16'h1);
        chk("dl_owner_cpu", 16'(bus_owner), 16'h1);
        chk("dl_no_layer3", 16'(start_cnt - snap_s), 16'd3);
        cpu_req = 1'b0;
        tick(); tick();
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;

        // CPU holds the bus across a line event
        cpu_req = 1'b1;
        tick(); #1;
        chk("cpu_ack_on", 16'(cpu_ack), 16'h1);
        snap_s = start_cnt;
        vc = 9'd40; hbl = 1'b1;
        repeat (20) tick();
        #1;
        chk("cpu_nostart", 16'(start_cnt - snap_s), 16'h0);
        chk("cpu_still_ack", 16'(cpu_ack), 16'h1);
        cpu_req = 1'b0;
        tick(); #1;
        chk("cpu_idle_nostart", 16'(fetch_start), 16'h0);
        tick(); #1;
        chk("cpu_then_start", 16'(fetch_start), 16'b0001);
        chk("cpu_then_line", 16'(fetch_line), 16'd41);
        for (int i = 0; i < 4; i++) begin
            tick(); fetch_done = 4'(4'b0001 << i);
            tick(); fetch_done = 4'd0;
        end
        hbl = 1'b0; tick();

        // Pending fetch and cpu_req in the same IDLE cycle
        vc = 9'd50; hbl = 1'b1;
        tick(); cpu_req = 1'b1;
        tick(); #1;
        chk("col_fetch_wins", 16'(fetch_start), 16'b0001);
        chk("col_no_ack", 16'(cpu_ack), 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); fetch_done = 4'(4'b0001 << i);
            tick(); fetch_done = 4'd0;
        end
        #1;
        chk("col_idle_ack", 16'(cpu_ack), 16'h0);
        tick(); #1;
        chk("col_cpu_after", 16'(cpu_ack), 16'h1);
        cpu_req = 1'b0;
        tick(); tick();
        hbl = 1'b0; tick();

        // Reset while layer 1 waits
        vc = 9'd60; hbl = 1'b1;
        tick(); tick();
        tick(); fetch_done = 4'b0001;
        tick(); fetch_done = 4'd0;
        tick();
        #1;
        chk("rm_owner_pre", 16'(bus_owner), 16'd3);
        snap_a = abort_cnt;
        snap_s = start_cnt;
        reset = 1'b1;
        tick(); #1;
        chk("rm_start", 16'(fetch_start), 16'h0);
        chk("rm_line", 16'(fetch_line), 16'h0);
        chk("rm_owner", 16'(bus_owner), 16'h0);
        chk("rm_abort", 16'(fetch_abort), 16'h0);
        chk("rm_ovr", 16'(overrun), 16'h0);
        reset = 1'b0; hbl = 1'b0;
        repeat (4) tick();
        #1;
        chk("rm_no_abort", 16'(abort_cnt - snap_a), 16'h0);
        chk("rm_no_restart", 16'(start_cnt - snap_s), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
